// File: rtl/jpeg_pkg.sv
// Shared JPEG decode-path definitions: block geometry, sequencer state
// encoding and the raster-to-zigzag index table used by inverse_zigzag.
package jpeg_pkg;

    localparam logic [2:0]  ZZ_ROW_OFFSET = 3'd2;
    localparam int unsigned ROWS_PER_BLK  = 8;
    localparam int unsigned COEFS_PER_BLK = 64;

    typedef enum logic {
        IZZ_IDLE,
        IZZ_EMIT
    } izz_state_t;

    // Zigzag index of the coefficient at raster position {row, col}
    localparam logic [5:0] ZZ_IDX [COEFS_PER_BLK] = '{
         0,  1,  5,  6, 14, 15, 27, 28,
         2,  4,  7, 13, 16, 26, 29, 42,
         3,  8, 12, 17, 25, 30, 41, 43,
         9, 11, 18, 24, 31, 40, 44, 53,
        10, 19, 23, 32, 39, 45, 52, 54,
        20, 22, 33, 38, 46, 51, 55, 60,
        21, 34, 37, 47, 50, 56, 59, 61,
        35, 36, 48, 49, 57, 58, 62, 63
    };

endpackage

// File: rtl/inverse_zigzag.sv
// Combinational inverse zigzag: selects one raster row of a zigzag-ordered
// block; the row is encoded in address_in[2:0] with a +2 offset.
module inverse_zigzag
    import jpeg_pkg::*;
#(
    parameter int unsigned COEF_W = 8,
    parameter int unsigned ADDR_W = 15
) (
    input  logic [COEFS_PER_BLK*COEF_W-1:0] data_in,
    input  logic [ADDR_W-1:0]               address_in,
    output logic [ROWS_PER_BLK*COEF_W-1:0]  data_out
);

    logic [2:0] w_raster_row;
    logic [5:0] w_idx;
    // Upper address bits carry the block tag; row selection ignores them
    logic       w_unused_blk_tag;

    assign w_unused_blk_tag = ^address_in[ADDR_W-1:3];
    assign w_raster_row     = address_in[2:0] - ZZ_ROW_OFFSET;

    always_comb begin
        data_out = '0;
        w_idx    = '0;
        for (int unsigned c = 0; c < ROWS_PER_BLK; c++) begin
            w_idx = ZZ_IDX[{w_raster_row, c[2:0]}];
            data_out[(ROWS_PER_BLK-1-c)*COEF_W +: COEF_W] =
                data_in[(COEFS_PER_BLK-1-32'(w_idx))*COEF_W +: COEF_W];
        end
    end

endmodule

// File: rtl/izz_row_sequencer.sv
// Accepts one zigzag block per handshake and emits its eight raster rows
// through inverse_zigzag, one row per output handshake.
module izz_row_sequencer
    import jpeg_pkg::*;
#(
    parameter int unsigned COEF_W    = 8,
    parameter int unsigned BLK_CNT_W = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [COEFS_PER_BLK*COEF_W-1:0]   in_block,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ROWS_PER_BLK*COEF_W-1:0]    out_row_data,
    output logic [2:0]                        out_row,
    output logic                              out_last,
    output logic [BLK_CNT_W+2:0]              zz_addr,
    output logic [BLK_CNT_W-1:0]              blk_cnt
);

    localparam logic [2:0] LAST_ROW = 3'(ROWS_PER_BLK - 1);

    izz_state_t                      r_state;
    izz_state_t                      w_state_nxt;
    logic [COEFS_PER_BLK*COEF_W-1:0] r_block;
    logic [2:0]                      r_row;
    logic [BLK_CNT_W-1:0]            r_blk_cnt;
    logic                            w_accept;
    logic                            w_out_hs;
    logic                            w_row_last;
    logic [2:0]                      w_row_sel;

    assign w_row_last = (r_row == LAST_ROW);
    // flush suppresses both handshakes so no block is taken and no row consumed
    assign w_out_hs   = (r_state == IZZ_EMIT) && out_ready && !flush;
    assign w_accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IZZ_IDLE;
            r_block   <= '0;
            r_row     <= '0;
            r_blk_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_block <= in_block;
            end
            if (flush || w_accept) begin
                r_row <= '0;
            end else if (w_out_hs && !w_row_last) begin
                r_row <= r_row + 3'd1;
            end
            if (w_out_hs && w_row_last) begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IZZ_IDLE: if (w_accept) w_state_nxt = IZZ_EMIT;
            IZZ_EMIT: begin
                if (flush) begin
                    w_state_nxt = IZZ_IDLE;
                end else if (w_out_hs && w_row_last) begin
                    w_state_nxt = w_accept ? IZZ_EMIT : IZZ_IDLE;
                end
            end
            default:  w_state_nxt = IZZ_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == IZZ_EMIT);
        out_last  = (r_state == IZZ_EMIT) && w_row_last;
        in_ready  = !flush && ((r_state == IZZ_IDLE) ||
                               ((r_state == IZZ_EMIT) && out_ready && w_row_last));
        w_row_sel = r_row + ZZ_ROW_OFFSET;
        out_row   = r_row;
        blk_cnt   = r_blk_cnt;
        zz_addr   = {r_blk_cnt, w_row_sel};
    end

    inverse_zigzag #(
        .COEF_W (COEF_W),
        .ADDR_W (BLK_CNT_W + 3)
    ) u_inverse_zigzag (
        .data_in    (r_block),
        .address_in (zz_addr),
        .data_out   (out_row_data)
    );

endmodule

// File: tb/tb_izz_row_sequencer.sv
// Directed bench for izz_row_sequencer with hand-computed expected rows.
module tb_izz_row_sequencer;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_row_data;
    logic [2:0]   out_row;
    logic         out_last;
    logic [14:0]  zz_addr;
    logic [11:0]  blk_cnt;

    int unsigned  checks;
    int unsigned  failures;
    logic [511:0] blk_a;
    logic [511:0] blk_b;

    localparam logic [63:0] ROW0_A = 64'h0001_0506_0E0F_1B1C;
    localparam logic [63:0] ROW3_A = 64'h090B_1218_1F28_2C35;
    localparam logic [63:0] ROW5_A = 64'h1416_2126_2E33_373C;
    localparam logic [63:0] ROW7_A = 64'h2324_3031_393A_3E3F;

    izz_row_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_block     (in_block),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row_data (out_row_data),
        .out_row      (out_row),
        .out_last     (out_last),
        .zz_addr      (zz_addr),
        .blk_cnt      (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        for (int k = 0; k < 64; k++) begin
            blk_a[511-8*k -: 8] = 8'(k);
            blk_b[511-8*k -: 8] = 8'(255 - k);
        end

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_out_row",   64'(out_row),   64'd0);
        chk("rst_zz_addr",   64'(zz_addr),   64'h0002);
        chk("rst_blk_cnt",   64'(blk_cnt),   64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // 1: single block, free-running output
        in_valid = 1'b1;
        in_block = blk_a;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            chk("t1_out_valid", 64'(out_valid), 64'd1);
            chk("t1_out_row",   64'(out_row),   64'(r));
            chk("t1_out_last",  64'(out_last),  64'(r == 7));
            chk("t1_in_ready",  64'(in_ready),  64'(r == 7));
            chk("t1_row_sel",   64'(zz_addr[2:0]), 64'((r + 2) % 8));
            if (r == 0) chk("t1_row0_data", out_row_data, ROW0_A);
            if (r == 3) chk("t1_row3_data", out_row_data, ROW3_A);
            if (r == 5) chk("t1_row5_data", out_row_data, ROW5_A);
            if (r == 7) chk("t1_row7_data", out_row_data, ROW7_A);
            step();
        end
        @(negedge clk);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);
        chk("t1_blk_cnt",    64'(blk_cnt),   64'd1);
        chk("t1_in_ready",   64'(in_ready),  64'd1);

        // 2: back-to-back blocks with no bubble
        in_valid = 1'b1;
        in_block = blk_a;
        step();
        in_block = blk_b;
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            chk("t2a_out_valid", 64'(out_valid), 64'd1);
            chk("t2a_out_row",   64'(out_row),   64'(r));
            chk("t2a_in_ready",  64'(in_ready),  64'(r == 7));
            if (r == 0) chk("t2a_row0_data", out_row_data, ROW0_A);
            step();
            if (r == 7) in_valid = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            chk("t2b_out_valid", 64'(out_valid), 64'd1);
            chk("t2b_out_row",   64'(out_row),   64'(r));
            if (r == 0) chk("t2b_row0_data", out_row_data, ~ROW0_A);
            if (r == 7) chk("t2b_row7_data", out_row_data, ~ROW7_A);
            step();
        end
        @(negedge clk);
        chk("t2_idle_valid", 64'(out_valid), 64'd0);
        chk("t2_blk_cnt",    64'(blk_cnt),   64'd3);

        // 3: stall at row 3
        in_valid = 1'b1;
        in_block = blk_a;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_valid", 64'(out_valid),    64'd1);
            chk("t3_stall_row",   64'(out_row),      64'd3);
            chk("t3_stall_data",  out_row_data,      ROW3_A);
            chk("t3_stall_sel",   64'(zz_addr[2:0]), 64'b101);
            chk("t3_stall_last",  64'(out_last),     64'd0);
            chk("t3_stall_rdy",   64'(in_ready),     64'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_row", 64'(out_row), 64'd3);
        step();
        @(negedge clk);
        chk("t3_next_row", 64'(out_row), 64'd4);
        repeat (4) step();
        @(negedge clk);
        chk("t3_idle_valid", 64'(out_valid), 64'd0);
        chk("t3_blk_cnt",    64'(blk_cnt),   64'd4);

        // 4: flush at row 5 with a competing block on the input
        in_valid = 1'b1;
        in_block = blk_a;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_block = blk_b;
        @(negedge clk);
        chk("t4_flush_rdy",  64'(in_ready),  64'd0);
        chk("t4_flush_row",  64'(out_row),   64'd5);
        chk("t4_flush_data", out_row_data,   ROW5_A);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_idle_valid", 64'(out_valid), 64'd0);
        chk("t4_idle_row",   64'(out_row),   64'd0);
        chk("t4_blk_cnt",    64'(blk_cnt),   64'd4);
        chk("t4_zz_addr",    64'(zz_addr),   64'h0022);
        chk("t4_in_ready",   64'(in_ready),  64'd1);

        // 5: asynchronous reset mid-block
        in_valid = 1'b1;
        in_block = blk_a;
        step();
        in_valid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("t5_pre_row", 64'(out_row), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",   64'(out_valid), 64'd0);
        chk("t5_rst_zz_addr", 64'(zz_addr),   64'h0002);
        chk("t5_rst_blk_cnt", 64'(blk_cnt),   64'd0);
        chk("t5_rst_last",    64'(out_last),  64'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_block = blk_b;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_restart_valid", 64'(out_valid), 64'd1);
        chk("t5_restart_row",   64'(out_row),   64'd0);
        chk("t5_restart_data",  out_row_data,   ~ROW0_A);
        repeat (8) step();

        // 6: block counter wrap
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_block = blk_a;
        repeat (1 + 8 * 4095) @(posedge clk);
        #1;
        @(negedge clk);
        chk("t6_blk_cnt_max", 64'(blk_cnt), 64'd4095);
        chk("t6_zz_addr_max", 64'(zz_addr), 64'h7FFA);
        chk("t6_row_after",   64'(out_row), 64'd0);
        in_valid = 1'b0;
        repeat (8) step();
        @(negedge clk);
        chk("t6_blk_cnt_wrap", 64'(blk_cnt),       64'd0);
        chk("t6_zz_tag_wrap",  64'(zz_addr[14:3]), 64'd0);
        chk("t6_idle_valid",   64'(out_valid),     64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
